// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- RV32I program-counter sequencer and instruction-fetch handshake.
//
// Each cycle this block computes the value the external pc_counter loads on the
// next rising edge. It also drives the req/ack handshake to instruction memory.
// It arbitrates between these sources of the next PC:
//   - sequential advance,
//   - branch/jump redirect,
//   - decode stall,
//   - halt/resume,
//   - misaligned-target trap.
//
// Ports
//   clk_pc          in   1   single clock, rising edge
//   rst_pc          in   1   synchronous, active-low reset
//   pc_cur          in  32   current PC (pc_counter output)
//   pc_next         out 32   next PC (pc_counter input), combinational
//   imem_req        out  1   fetch request, registered
//   imem_addr       out 32   fetch address (follows pc_cur)
//   imem_ack        in   1   memory accepted/returned the fetch this cycle
//   fetch_valid     out  1   fetched instruction valid for decode, combinational
//   stall           in   1   decode hazard, blocks a new fetch in FETCH
//   redirect        in   1   taken branch/jump pulse
//   redirect_target in  32   target of redirect
//   halt            in   1   ecall/ebreak halt request
//   resume          in   1   leave HALT
//   trap            out  1   one-cycle pulse on misaligned redirect target
//   bad_addr        out 32   last misaligned redirect target
//   state           out  2   BOOT=0, FETCH=1, WAIT=2, HALT=3
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk_pc,
  input  logic        rst_pc,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        fetch_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  input  logic        resume,
  output logic        trap,
  output logic [31:0] bad_addr,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        trap_q, trap_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic        rdr_pend_q, rdr_pend_d;
  logic [31:0] rdr_tgt_q, rdr_tgt_d;
  logic        halt_pend_q, halt_pend_d;

  logic [31:0] pc_next_s;
  logic        fetch_valid_s;
  logic        misaligned_s;
  logic [31:0] redir_pc_s;
  logic [31:0] pc_inc_s;

  // A redirect to a non-word-aligned target is replaced by the trap vector.
  assign misaligned_s = |redirect_target[1:0];
  assign redir_pc_s   = misaligned_s ? TRAP_VECTOR : redirect_target;
  // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
  assign pc_inc_s     = pc_cur + 32'd4;

  // Next-state, next-PC, and handshake decisions.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    trap_d        = 1'b0;
    bad_addr_d    = bad_addr_q;
    rdr_pend_d    = rdr_pend_q;
    rdr_tgt_d     = rdr_tgt_q;
    halt_pend_d   = halt_pend_q;
    pc_next_s     = pc_cur;
    fetch_valid_s = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_next_s = RESET_VECTOR;
        req_d     = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_FETCH: begin
        if (halt) begin
          req_d   = 1'b0;
          state_d = ST_HALT;
        end else if (redirect) begin
          // The redirect cycle drops any ack, and the following cycle is a bubble.
          pc_next_s = redir_pc_s;
          req_d     = 1'b0;
          if (misaligned_s) begin
            trap_d     = 1'b1;
            bad_addr_d = redirect_target;
          end else begin
            trap_d = 1'b0;
          end
        end else if (stall) begin
          req_d = 1'b0;
        end else if (!req_q) begin
          // Bubble cycle: no request is on the bus, so an ack here means nothing.
          req_d = 1'b1;
        end else if (imem_ack) begin
          fetch_valid_s = 1'b1;
          pc_next_s     = pc_inc_s;
          req_d         = 1'b1;
        end else begin
          req_d   = 1'b1;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // The request stays up until ack, and stall has no effect here.
        req_d = 1'b1;
        if (redirect) begin
          rdr_pend_d = 1'b1;
          rdr_tgt_d  = redir_pc_s;
          if (misaligned_s) begin
            trap_d     = 1'b1;
            bad_addr_d = redirect_target;
          end else begin
            trap_d = 1'b0;
          end
        end else begin
          rdr_pend_d = rdr_pend_q;
        end
        if (halt) begin
          halt_pend_d = 1'b1;
        end else begin
          halt_pend_d = halt_pend_q;
        end
        if (imem_ack) begin
          // A redirect arriving together with the ack counts as pending.
          if (redirect || rdr_pend_q) begin
            pc_next_s = redirect ? redir_pc_s : rdr_tgt_q;
            state_d   = ST_FETCH;
            req_d     = 1'b1;
          end else if (halt || halt_pend_q) begin
            fetch_valid_s = 1'b1;
            pc_next_s     = pc_inc_s;
            state_d       = ST_HALT;
            req_d         = 1'b0;
          end else begin
            fetch_valid_s = 1'b1;
            pc_next_s     = pc_inc_s;
            state_d       = ST_FETCH;
            req_d         = 1'b1;
          end
          rdr_pend_d  = 1'b0;
          halt_pend_d = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_HALT: begin
        req_d = 1'b0;
        if (redirect) begin
          pc_next_s = redirect_target;
        end else begin
          pc_next_s = pc_cur;
        end
        if (resume) begin
          req_d   = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end

      default: begin
        req_d   = 1'b0;
        state_d = ST_BOOT;
      end
    endcase

    // While reset is held, pc_counter loads the reset vector.
    if (!rst_pc) begin
      pc_next_s     = RESET_VECTOR;
      fetch_valid_s = 1'b0;
    end else begin
      pc_next_s     = pc_next_s;
      fetch_valid_s = fetch_valid_s;
    end
  end

  // State, handshake, and trap registers with synchronous active-low reset.
  always_ff @(posedge clk_pc) begin
    if (!rst_pc) begin
      state_q     <= ST_BOOT;
      req_q       <= 1'b0;
      trap_q      <= 1'b0;
      bad_addr_q  <= 32'h0000_0000;
      rdr_pend_q  <= 1'b0;
      rdr_tgt_q   <= 32'h0000_0000;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      trap_q      <= trap_d;
      bad_addr_q  <= bad_addr_d;
      rdr_pend_q  <= rdr_pend_d;
      rdr_tgt_q   <= rdr_tgt_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign pc_next     = pc_next_s;
  assign fetch_valid = fetch_valid_s;
  assign imem_req    = req_q;
  assign imem_addr   = pc_cur;
  assign trap        = trap_q;
  assign bad_addr    = bad_addr_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl.
// The bench models pc_counter as a register that loads pc_next every edge.
// Per-cycle vectors are pushed to a scoreboard queue when driven. They are
// popped and compared on the falling edge.
module tb_pc_fetch_ctrl;

  logic        clk_pc;
  logic        rst_pc;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        fetch_valid;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt;
  logic        resume;
  logic        trap;
  logic [31:0] bad_addr;
  logic [1:0]  state;

  int n_tests;
  int n_fail;

  pc_fetch_ctrl dut (
    .clk_pc          (clk_pc),
    .rst_pc          (rst_pc),
    .pc_cur          (pc_cur),
    .pc_next         (pc_next),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .fetch_valid     (fetch_valid),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .resume          (resume),
    .trap            (trap),
    .bad_addr        (bad_addr),
    .state           (state)
  );

  initial clk_pc = 1'b0;
  always #5 clk_pc = ~clk_pc;

  // pc_counter model
  always @(posedge clk_pc) pc_cur <= pc_next;

  // Inputs: {ack, stall, redirect, halt, resume}
  // Expected flags: {req, valid, trap}
  typedef struct {
    logic [4:0]  in;
    logic [31:0] tgt;
    logic [1:0]  st;
    logic [2:0]  fl;
    logic [31:0] pc;
    logic [31:0] pnx;
    logic [31:0] bad;
  } vec_t;

  localparam int NV = 38;
  vec_t vecs [NV];
  vec_t sb_q [$];

  function automatic vec_t mk(input logic [4:0] in, input logic [31:0] tgt, input logic [1:0] st,
                              input logic [2:0] fl, input logic [31:0] pc, input logic [31:0] pnx,
                              input logic [31:0] bad);
    vec_t v;
    v.in = in; v.tgt = tgt; v.st = st; v.fl = fl; v.pc = pc; v.pnx = pnx; v.bad = bad;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {imem_ack, stall, redirect, halt, resume} = v.in;
    redirect_target = v.tgt;
  endtask

  task automatic compare(input vec_t v, input int idx);
    chk("state",       idx, {30'd0, state},       {30'd0, v.st});
    chk("imem_req",    idx, {31'd0, imem_req},    {31'd0, v.fl[2]});
    chk("fetch_valid", idx, {31'd0, fetch_valid}, {31'd0, v.fl[1]});
    chk("trap",        idx, {31'd0, trap},        {31'd0, v.fl[0]});
    chk("pc_cur",      idx, pc_cur,               v.pc);
    chk("imem_addr",   idx, imem_addr,            v.pc);
    chk("pc_next",     idx, pc_next,              v.pnx);
    chk("bad_addr",    idx, bad_addr,             v.bad);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = mk(5'b00000, 32'h0,        2'd0, 3'b000, 32'h0,        32'h0,        32'h0);
    vecs[1]  = mk(5'b10000, 32'h0,        2'd1, 3'b110, 32'h0,        32'h4,        32'h0);
    vecs[2]  = mk(5'b10000, 32'h0,        2'd1, 3'b110, 32'h4,        32'h8,        32'h0);
    vecs[3]  = mk(5'b00000, 32'h0,        2'd1, 3'b100, 32'h8,        32'h8,        32'h0);
    vecs[4]  = mk(5'b00000, 32'h0,        2'd2, 3'b100, 32'h8,        32'h8,        32'h0);
    vecs[5]  = mk(5'b10000, 32'h0,        2'd2, 3'b110, 32'h8,        32'hC,        32'h0);
    vecs[6]  = mk(5'b00000, 32'h0,        2'd1, 3'b100, 32'hC,        32'hC,        32'h0);
    vecs[7]  = mk(5'b00100, 32'h40,       2'd2, 3'b100, 32'hC,        32'hC,        32'h0);
    vecs[8]  = mk(5'b10000, 32'h0,        2'd2, 3'b100, 32'hC,        32'h40,       32'h0);
    vecs[9]  = mk(5'b10000, 32'h0,        2'd1, 3'b110, 32'h40,       32'h44,       32'h0);
    vecs[10] = mk(5'b10100, 32'h42,       2'd1, 3'b100, 32'h44,       32'h100,      32'h0);
    vecs[11] = mk(5'b10000, 32'h0,        2'd1, 3'b001, 32'h100,      32'h100,      32'h42);
    vecs[12] = mk(5'b10100, 32'h10,       2'd1, 3'b100, 32'h100,      32'h10,       32'h42);
    vecs[13] = mk(5'b10000, 32'h0,        2'd1, 3'b000, 32'h10,       32'h10,       32'h42);
    vecs[14] = mk(5'b10010, 32'h0,        2'd1, 3'b100, 32'h10,       32'h10,       32'h42);
    vecs[15] = mk(5'b00000, 32'h0,        2'd3, 3'b000, 32'h10,       32'h10,       32'h42);
    vecs[16] = mk(5'b00001, 32'h0,        2'd3, 3'b000, 32'h10,       32'h10,       32'h42);
    vecs[17] = mk(5'b10000, 32'h0,        2'd1, 3'b110, 32'h10,       32'h14,       32'h42);
    vecs[18] = mk(5'b11000, 32'h0,        2'd1, 3'b100, 32'h14,       32'h14,       32'h42);
    vecs[19] = mk(5'b01000, 32'h0,        2'd1, 3'b000, 32'h14,       32'h14,       32'h42);
    vecs[20] = mk(5'b01000, 32'h0,        2'd1, 3'b000, 32'h14,       32'h14,       32'h42);
    vecs[21] = mk(5'b00000, 32'h0,        2'd1, 3'b000, 32'h14,       32'h14,       32'h42);
    vecs[22] = mk(5'b10000, 32'h0,        2'd1, 3'b110, 32'h14,       32'h18,       32'h42);
    vecs[23] = mk(5'b00000, 32'h0,        2'd1, 3'b100, 32'h18,       32'h18,       32'h42);
    vecs[24] = mk(5'b01010, 32'h0,        2'd2, 3'b100, 32'h18,       32'h18,       32'h42);
    vecs[25] = mk(5'b10000, 32'h0,        2'd2, 3'b110, 32'h18,       32'h1C,       32'h42);
    vecs[26] = mk(5'b00100, 32'hFFFF_FFFC, 2'd3, 3'b000, 32'h1C,      32'hFFFF_FFFC, 32'h42);
    vecs[27] = mk(5'b00001, 32'h0,        2'd3, 3'b000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h42);
    vecs[28] = mk(5'b10000, 32'h0,        2'd1, 3'b110, 32'hFFFF_FFFC, 32'h0,       32'h42);
    vecs[29] = mk(5'b00000, 32'h0,        2'd1, 3'b100, 32'h0,        32'h0,        32'h42);
    vecs[30] = mk(5'b00100, 32'h21,       2'd2, 3'b100, 32'h0,        32'h0,        32'h42);
    vecs[31] = mk(5'b00100, 32'h80,       2'd2, 3'b101, 32'h0,        32'h0,        32'h21);
    vecs[32] = mk(5'b10000, 32'h0,        2'd2, 3'b100, 32'h0,        32'h80,       32'h21);
    vecs[33] = mk(5'b00000, 32'h0,        2'd1, 3'b100, 32'h80,       32'h80,       32'h21);
    vecs[34] = mk(5'b10100, 32'h200,      2'd2, 3'b100, 32'h80,       32'h200,      32'h21);
    vecs[35] = mk(5'b10000, 32'h0,        2'd1, 3'b110, 32'h200,      32'h204,      32'h21);
    vecs[36] = mk(5'b00000, 32'h0,        2'd1, 3'b100, 32'h204,      32'h204,      32'h21);
    vecs[37] = mk(5'b00100, 32'h300,      2'd2, 3'b100, 32'h204,      32'h204,      32'h21);

    // Reset held for two cycles
    rst_pc = 1'b0;
    drive(mk(5'b00000, 32'h0, 2'd0, 3'b000, 32'h0, 32'h0, 32'h0));
    repeat (2) @(posedge clk_pc);
    @(negedge clk_pc);
    chk("rst_state",    -1, {30'd0, state},    32'd0);
    chk("rst_req",      -1, {31'd0, imem_req}, 32'd0);
    chk("rst_pc_next",  -1, pc_next,           32'h0);
    chk("rst_trap",     -1, {31'd0, trap},     32'd0);
    chk("rst_bad_addr", -1, bad_addr,          32'h0);
    @(posedge clk_pc); #1;
    rst_pc = 1'b1;

    // Table-driven run through the scoreboard
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      sb_q.push_back(vecs[i]);
      @(negedge clk_pc);
      e = sb_q.pop_front();
      compare(e, i);
      @(posedge clk_pc); #1;
    end

    // Reset while in WAIT with a redirect pending
    chk("pre_rst_state", 100, {30'd0, state}, 32'd2);
    rst_pc = 1'b0;
    drive(mk(5'b00000, 32'h0, 2'd0, 3'b000, 32'h0, 32'h0, 32'h0));
    @(posedge clk_pc);
    @(negedge clk_pc);
    chk("midwait_rst_state", 101, {30'd0, state},    32'd0);
    chk("midwait_rst_req",   101, {31'd0, imem_req}, 32'd0);
    chk("midwait_rst_bad",   101, bad_addr,          32'h0);
    chk("midwait_rst_pc",    101, pc_cur,            32'h0);
    @(posedge clk_pc); #1;
    rst_pc   = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk_pc);
    chk("boot_state",   102, {30'd0, state},       32'd0);
    chk("boot_pc_next", 102, pc_next,              32'h0);
    chk("boot_valid",   102, {31'd0, fetch_valid}, 32'd0);
    @(posedge clk_pc); #1;
    @(negedge clk_pc);
    chk("post_rst_state",   103, {30'd0, state},       32'd1);
    chk("post_rst_req",     103, {31'd0, imem_req},    32'd1);
    chk("post_rst_valid",   103, {31'd0, fetch_valid}, 32'd1);
    chk("post_rst_pc_next", 103, pc_next,              32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
